// File: rtl/uart_word_rx_if.sv
// Serial input and assembled-word outputs of uart_word_rx.
// master is the receiver side, slave is the downstream command controller side.
interface uart_word_rx_if;
  logic        uart_rx;
  logic [31:0] rx;
  logic        rxValid;
  logic        frame_err;
  logic        word_timeout;

  modport master (
    input  uart_rx,
    output rx,
    output rxValid,
    output frame_err,
    output word_timeout
  );

  modport slave (
    output uart_rx,
    input  rx,
    input  rxValid,
    input  frame_err,
    input  word_timeout
  );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver packing 4 bytes into a 32-bit word; word valid 1 cycle after the 4th stop sample.
// No backpressure: rxValid/frame_err/word_timeout are single-cycle pulses the consumer must take.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 4340,
  parameter int TIMEOUT_CLKS = 434000
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_word_rx_if.master bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic          sync1, rxs;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [23:0]   word, word_n;
  logic [1:0]    bcnt, bcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [31:0]   rx_q, rx_n;
  logic          vld_q, vld_n;
  logic          fe_q, fe_n;
  logic          to_q, to_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.uart_rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      word    <= '0;
      bcnt    <= '0;
      tcnt    <= '0;
      rx_q    <= '0;
      vld_q   <= 1'b0;
      fe_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      word    <= word_n;
      bcnt    <= bcnt_n;
      tcnt    <= tcnt_n;
      rx_q    <= rx_n;
      vld_q   <= vld_n;
      fe_q    <= fe_n;
      to_q    <= to_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    word_n    = word;
    bcnt_n    = bcnt;
    tcnt_n    = tcnt;
    rx_n      = rx_q;
    vld_n     = 1'b0;
    fe_n      = 1'b0;
    to_n      = 1'b0;

    case (state)
      IDLE: begin
        // A timeout firing on the same cycle as a start edge still clears the
        // byte count, so the incoming byte opens a fresh word.
        if (bcnt != 2'd0) begin
          if (tcnt == TO_LAST) begin
            bcnt_n = 2'd0;
            to_n   = 1'b1;
            tcnt_n = '0;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
          tcnt_n  = '0;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
            tcnt_n  = '0;
            word_n  = {word[15:0], shreg};
            if (bcnt == 2'd3) begin
              rx_n   = {word, shreg};
              vld_n  = 1'b1;
              bcnt_n = 2'd0;
            end else begin
              bcnt_n = bcnt + 2'd1;
            end
          end else begin
            // Stale bytes left in word are fully shifted out by the next 4 bytes.
            fe_n    = 1'b1;
            bcnt_n  = 2'd0;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      WAIT_HIGH: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.rx           = rx_q;
  assign bus.rxValid      = vld_q;
  assign bus.frame_err    = fe_q;
  assign bus.word_timeout = to_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed table, hand sequences and randomized frames against a byte-queue model.
module tb_uart_word_rx;
  localparam int CPB  = 8;
  localparam int TO   = 200;
  localparam int TAIL = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_word_rx_if bus();

  uart_word_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accumulates only; checks use baselines captured per scenario.
  logic [31:0] got_w[$];
  int          got_wc[$];
  int          fe_tot = 0, to_tot = 0, excl_tot = 0, to_cyc = -1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rxValid) begin
        got_w.push_back(bus.rx);
        got_wc.push_back(cyc);
      end
      if (bus.frame_err) fe_tot++;
      if (bus.word_timeout) begin
        to_tot++;
        to_cyc = cyc;
      end
      if (int'(bus.rxValid) + int'(bus.frame_err) + int'(bus.word_timeout) > 1) excl_tot++;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Frame list for the next scenario: byte, stop-bit good, idle cycles before it.
  logic [7:0] fb[$];
  bit         fok[$];
  int         fgap[$];
  int         starts[$];
  logic [31:0] exp_w[$];
  int base_w, base_fe, base_to, base_ex;

  task automatic clear_frames();
    fb.delete(); fok.delete(); fgap.delete(); starts.delete(); exp_w.delete();
  endtask

  task automatic add_frame(input logic [7:0] b, input bit ok, input int gap);
    fb.push_back(b); fok.push_back(ok); fgap.push_back(gap);
  endtask

  task automatic mark();
    base_w  = got_w.size();
    base_fe = fe_tot;
    base_to = to_tot;
    base_ex = excl_tot;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.uart_rx = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok, output int st);
    @(negedge clk);
    st = cyc;
    bus.uart_rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.uart_rx = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.uart_rx = ok;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic run_frames();
    int st;
    for (int i = 0; i < fb.size(); i++) begin
      idle(fgap[i]);
      send_frame(fb[i], fok[i], st);
      starts.push_back(st);
    end
    idle(TAIL);
  endtask

  task automatic check_expect(input string tag, input int efe, input int eto);
    logic [31:0] g;
    check({tag, "_nwords"}, 32'(got_w.size() - base_w), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      g = (base_w + i < got_w.size()) ? got_w[base_w + i] : 32'hxxxx_xxxx;
      check($sformatf("%s_word%0d", tag, i), g, exp_w[i]);
    end
    check({tag, "_frame_err"}, 32'(fe_tot - base_fe), 32'(efe));
    check({tag, "_timeout"}, 32'(to_tot - base_to), 32'(eto));
    check({tag, "_exclusive"}, 32'(excl_tot - base_ex), 32'd0);
    if (exp_w.size() > 0) check({tag, "_rx_hold"}, bus.rx, exp_w[exp_w.size() - 1]);
  endtask

  // Reference: bytes queue up; 4 make a word; a bad stop or an idle stretch
  // (half a bit after the stop sample plus the gap) reaching TO discards them.
  task automatic check_model(input string tag);
    logic [7:0] pend[$];
    int efe = 0, eto = 0;
    exp_w.delete();
    for (int i = 0; i < fb.size(); i++) begin
      if (pend.size() > 0 && CPB / 2 + fgap[i] >= TO) begin
        eto++;
        pend.delete();
      end
      if (!fok[i]) begin
        efe++;
        pend.delete();
      end else begin
        pend.push_back(fb[i]);
        if (pend.size() == 4) begin
          exp_w.push_back({pend[0], pend[1], pend[2], pend[3]});
          pend.delete();
        end
      end
    end
    if (pend.size() > 0 && CPB / 2 + TAIL >= TO) eto++;
    check_expect(tag, efe, eto);
  endtask

  typedef struct {
    int          n;
    logic [95:0] bytes;
    int          bad_idx;
    int          big_idx;
    int          big_gap;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          fe;
    int          to;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d, n, gap;
    bit ok, prev_bad;

    tbl[0] = '{4, {32'hFFFF_FFFF, 64'h0}, -1, -1, 0, 1, 32'hFFFF_FFFF, 32'h0, 0, 0};
    tbl[1] = '{8, {64'hEEEE_EEEE_DDDD_DDDD, 32'h0}, -1, -1, 0, 2, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 0, 0};
    tbl[2] = '{7, {56'h12_34_5A_BB_BB_BB_BB, 40'h0}, 2, -1, 0, 1, 32'hBBBB_BBBB, 32'h0, 1, 0};
    tbl[3] = '{7, {56'h12_34_56_11_22_33_44, 40'h0}, -1, 3, 250, 1, 32'h1122_3344, 32'h0, 0, 1};
    tbl[4] = '{7, {56'hA1_A2_A3_B1_B2_B3_B4, 40'h0}, -1, 3, TO - CPB / 2, 1, 32'hB1B2_B3B4, 32'h0, 0, 1};
    tbl[5] = '{7, {56'hA1_A2_A3_B1_B2_B3_B4, 40'h0}, -1, 3, TO - CPB / 2 - 1, 1, 32'hA1A2_A3B1, 32'h0, 0, 1};

    bus.uart_rx = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx", bus.rx, 32'h0);
    check("reset_rxValid", 32'(bus.rxValid), 32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_word_timeout", 32'(bus.word_timeout), 32'd0);
    rst_n = 1'b1;
    idle(10);

    for (int r = 0; r < 6; r++) begin
      clear_frames();
      for (int i = 0; i < tbl[r].n; i++) begin
        gap = (i == tbl[r].big_idx) ? tbl[r].big_gap : ((i > 0 && i - 1 == tbl[r].bad_idx) ? 3 : 0);
        add_frame(tbl[r].bytes[95 - 8 * i -: 8], i != tbl[r].bad_idx, gap);
      end
      if (tbl[r].nw > 0) exp_w.push_back(tbl[r].w0);
      if (tbl[r].nw > 1) exp_w.push_back(tbl[r].w1);
      mark();
      run_frames();
      check_expect($sformatf("row%0d", r), tbl[r].fe, tbl[r].to);
    end

    // Latency: rxValid 77 cycles after the 4th start edge reaches rxs (2 sync stages).
    clear_frames();
    for (int i = 0; i < 4; i++) add_frame(8'hFF, 1'b1, 0);
    mark();
    run_frames();
    check_model("latency");
    check("latency_cycle", 32'((got_w.size() > base_w) ? got_wc[base_w] : -1),
          32'(starts[3] + 2 + CPB / 2 + 9 * CPB + 1));

    // Timeout position relative to the 3rd stop sample.
    clear_frames();
    add_frame(8'h12, 1'b1, 0);
    add_frame(8'h34, 1'b1, 0);
    add_frame(8'h56, 1'b1, 0);
    mark();
    run_frames();
    check_model("to_only");
    d = to_cyc - (starts[2] + 2 + CPB / 2 + 9 * CPB);
    check("to_delay_window", 32'(d >= TO - 5 && d <= TO + 5), 32'd1);

    // Short low glitch while idle, then a full word.
    clear_frames();
    add_frame(8'hAA, 1'b1, 20);
    add_frame(8'hBB, 1'b1, 0);
    add_frame(8'hCC, 1'b1, 0);
    add_frame(8'hDD, 1'b1, 0);
    mark();
    idle(10);
    @(negedge clk) bus.uart_rx = 1'b0;
    @(negedge clk) bus.uart_rx = 1'b0;
    run_frames();
    check_model("glitch");

    // Reset in the middle of the 3rd byte.
    begin
      int st;
      send_frame(8'hC1, 1'b1, st);
      send_frame(8'hC2, 1'b1, st);
      @(negedge clk) bus.uart_rx = 1'b0;
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_rx", bus.rx, 32'h0);
      check("midreset_rxValid", 32'(bus.rxValid), 32'd0);
      bus.uart_rx = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      clear_frames();
      add_frame(8'h01, 1'b1, 20);
      add_frame(8'h02, 1'b1, 0);
      add_frame(8'h03, 1'b1, 0);
      add_frame(8'h04, 1'b1, 0);
      mark();
      run_frames();
      check_model("after_reset");
    end

    // Randomized frames: occasional bad stop bits and long gaps.
    for (int s = 0; s < 5; s++) begin
      clear_frames();
      n = $urandom_range(6, 10);
      prev_bad = 1'b0;
      for (int i = 0; i < n; i++) begin
        ok  = ($urandom_range(0, 7) != 0);
        gap = ($urandom_range(0, 5) == 0) ? $urandom_range(220, 300) : $urandom_range(0, 12);
        if (prev_bad && gap < 3) gap = 3;
        add_frame(8'($urandom), ok, gap);
        prev_bad = !ok;
      end
      mark();
      run_frames();
      check_model($sformatf("rand%0d", s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- UART receiver and word assembler. It sits directly upstream of the command controller and drives that controller's `rx`/`rxValid` inputs.
- Deserialises 8N1 bytes from the host serial line and packs 4 consecutive bytes into one 32-bit command word.
- Emits each completed word with a single-cycle valid pulse.
- Resynchronises on framing errors and on inter-byte timeouts, so a lost byte never shifts every later word.

Parameters:
- CLKS_PER_BIT, 4340, clk cycles per UART bit (500 MHz / 115200); must be >= 4.
- TIMEOUT_CLKS, 434000, idle cycles after a byte's stop sample before a partial word is discarded (about 100 bit times).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- uart_rx  input  1  asynchronous serial line; idles high.
- rx  output  32  last completed word; the first received byte is rx[31:24].
- rxValid  output  1  one-cycle pulse when rx has just been updated.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- word_timeout  output  1  one-cycle pulse when a partial word is discarded by timeout.

Behaviour:
- Reset (async assert; deassert is taken synchronously by the flops):
  - rx=0, rxValid=0, frame_err=0, word_timeout=0.
  - State IDLE, byte count=0, all counters=0.
  - Synchroniser flops reset to 1.
- Input path: uart_rx passes through a 2-flop synchroniser; rxs is the second flop. All decisions use rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rxs==0 -> START and clear the bit counter.
  - Otherwise the timeout counter runs while byte count is 1..3.
- START: when the counter reaches CLKS_PER_BIT/2-1 (integer division), sample rxs at mid-bit.
  - Sample 0 -> DATA, counter cleared.
  - Sample 1 -> glitch; return to IDLE with no output and byte count unchanged.
- DATA:
  - Sample rxs each time the counter reaches CLKS_PER_BIT-1, then clear the counter.
  - 8 samples are taken, LSB first, shifted into a byte register.
  - After the 8th sample -> STOP.
- STOP: sample at counter CLKS_PER_BIT-1.
  - Sample 1: the byte is accepted, shifted into the word register (word = {word[23:0], byte}) and byte count increments; go to IDLE.
  - If byte count was 3 (this is the 4th byte): on the next cycle rx <= assembled word, rxValid=1 for exactly that cycle, and byte count -> 0.
  - Sample 0: frame_err=1 on the next cycle, byte and partial word discarded, byte count -> 0; go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. A held-low break therefore produces exactly one frame_err.
- Latency: from the first cycle rxs==0 to the rxValid cycle = CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles for the 4th byte.
- rx holding: rx is unchanged except on a rxValid cycle; it holds the old word through errors and timeouts.
- Timeout:
  - The timeout counter clears on every accepted stop bit and on every START entry.
  - If it reaches TIMEOUT_CLKS-1 while in IDLE with byte count in 1..3: byte count -> 0 and word_timeout=1 for one cycle.
  - The counter does not run while byte count==0.
- Simultaneous events:
  - A start edge arriving in the same cycle the timeout fires: the timeout wins and the byte count clears. The new byte then begins a fresh word.
  - rxValid, frame_err and word_timeout are mutually exclusive by construction.
- Reset mid-frame: all state is lost immediately. The partial word is never emitted, and no pulse is emitted on reset release.

Test Plan:
- Directed scenarios use CLKS_PER_BIT=8 and TIMEOUT_CLKS=200.
- Send bytes FF,FF,FF,FF at 8 clk/bit -> one rxValid pulse with rx=FFFF_FFFF, 77 cycles after the 4th start edge reaches rxs; no frame_err.
- Send EE,EE,EE,EE then DD,DD,DD,DD back-to-back -> two rxValid pulses, rx=EEEE_EEEE then DDDD_DDDD; rx holds between pulses.
- Send 12,34, then a byte with stop bit forced 0, then BB,BB,BB,BB -> one frame_err; no word from 12/34; a single rxValid with rx=BBBB_BBBB.
- Send 12,34,56, idle 250 cycles, then 11,22,33,44 -> word_timeout pulse about 200 cycles after the 3rd stop sample; rxValid with rx=1122_3344, not 1234_5611.
- Send a 2-cycle low glitch on uart_rx while idle -> no state change beyond START->IDLE; no pulses; next 4 bytes AA,BB,CC,DD give rx=AABB_CCDD.
- Assert rst_n=0 midway through the 3rd byte of a word, then send 01,02,03,04 -> outputs go 0 asynchronously; exactly one rxValid with rx=0102_0304.
